nbit_seq_divider: RTL and testbench

Multi-cycle unsigned N-bit restoring divider built around the team's add/subtract datapath, run in the reverse direction: repeated trial subtraction instead of single-cycle addition. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after N iterations, signalling completion with a one-cycle done pulse. It sits beside the combinational arithmetic blocks for any datapath that needs division without a large combinational array.

---
 rtl/nbit_seq_divider.sv | 163 ++++++++++++++++
 tb/tb_nbit_seq_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nbit_seq_divider.sv
// rtl/nbit_seq_divider.sv - multi-cycle unsigned N-bit restoring divider
//
// Purpose: accepts a dividend/divisor pair on a start pulse in IDLE and
// produces quotient and remainder after N trial-subtraction iterations,
// flagging completion with a one-cycle done pulse.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   - a zero divisor bypasses RUN and finishes one cycle after start
//               with quotient all ones, remainder = dividend, div_by_zero_out=1
//   undefined - div_by_zero_out is tied low; a zero divisor runs the normal
//               N iterations, which yield the same quotient/remainder
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   request, sampled only in IDLE
//   dividend_in      in   [N-1:0] unsigned dividend, sampled with start
//   divisor_in       in   [N-1:0] unsigned divisor, sampled with start
//   busy             out  high in RUN and DONE
//   done             out  one-cycle pulse when results are valid
//   quotient_out     out  [N-1:0] quotient, held until next accepted start
//   remainder_out    out  [N-1:0] remainder, held until next accepted start
//   div_by_zero_out  out  divisor was zero, held with results

module nbit_seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend_in,
  input  logic [N-1:0] divisor_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient_out,
  output logic [N-1:0] remainder_out,
  output logic         div_by_zero_out
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;
  // Partial remainder is always < divisor between iterations, so its top bit
  // (the N+1-th) is always 0 and need not be stored.
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_divisor;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_remo;

  logic [N:0]    w_shift;
  logic [N:0]    w_trial;
  logic          w_borrow;
  logic [N-1:0]  w_rem_next;
  logic [N-1:0]  w_q_next;
  logic          w_last;
  logic          w_accept;
  logic          w_zero_skip;

  assign w_accept = (r_state == S_IDLE) && start;

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor with the adder run backwards (add the one's complement plus one).
  assign w_shift    = {r_rem, r_q[N-1]};
  assign w_trial    = w_shift + ~{1'b0, r_divisor} + {{N{1'b0}}, 1'b1};
  assign w_borrow   = w_trial[N];
  assign w_rem_next = w_borrow ? w_shift[N-1:0] : w_trial[N-1:0];
  assign w_q_next   = {r_q[N-2:0], ~w_borrow};
  assign w_last     = (r_cnt == CW'(N - 1));

`ifdef DIV_ZERO_DETECT_EN
  logic r_dbz;
  assign w_zero_skip     = w_accept && (divisor_in == '0);
  assign div_by_zero_out = r_dbz;
`else
  assign w_zero_skip     = 1'b0;
  assign div_by_zero_out = 1'b0;
`endif

  assign quotient_out  = r_quot;
  assign remainder_out = r_remo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_zero_skip ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_remo    <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dbz     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_divisor <= divisor_in;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= dividend_in;
`ifdef DIV_ZERO_DETECT_EN
      r_dbz     <= 1'b0;
      if (divisor_in == '0) begin
        // Results are published right away since RUN is skipped.
        r_quot <= '1;
        r_remo <= dividend_in;
        r_dbz  <= 1'b1;
      end
`endif
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot <= w_q_next;
        r_remo <= w_rem_next;
      end
    end
  end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// tb/tb_nbit_seq_divider.sv - self-checking bench for nbit_seq_divider (N=8 and N=4)

module tb_nbit_seq_divider;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] dd8, dv8, q8, r8;
  logic       busy8, done8, dbz8;

  logic       start4;
  logic [3:0] dd4, dv4, q4, r4;
  logic       busy4, done4, dbz4;

  int n_checks;
  int n_fail;
  int cyc;
  int k_prev;

  nbit_seq_divider #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .dividend_in(dd8), .divisor_in(dv8),
    .busy(busy8), .done(done8),
    .quotient_out(q8), .remainder_out(r8), .div_by_zero_out(dbz8)
  );

  nbit_seq_divider #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .dividend_in(dd4), .divisor_in(dv4),
    .busy(busy4), .done(done4),
    .quotient_out(q4), .remainder_out(r4), .div_by_zero_out(dbz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Full N=8 operation. hold keeps start high afterwards; poke>0 fires a
  // stray start with different operands that many cycles into RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold, input int poke);
    int c;
    int lat_exp;
    logic [7:0] eq, er;
    logic ez;
    eq = (b == 0) ? 8'hFF : a / b;
    er = (b == 0) ? a : a % b;
`ifdef DIV_ZERO_DETECT_EN
    lat_exp = (b == 0) ? 0 : 8;
    ez      = (b == 0);
`else
    lat_exp = 8;
    ez      = 1'b0;
`endif
    start8 = 1'b1; dd8 = a; dv8 = b;
    tick();
    k_prev = cyc;
    check("busy_on_accept", busy8, 1);
    if (!hold) start8 = 1'b0;
    c = 0;
    while (!done8 && c < 30) begin
      if (poke > 0 && c == poke) begin
        start8 = 1'b1; dd8 = ~a; dv8 = b + 8'd1;
      end else if (poke > 0 && c == poke + 1) begin
        start8 = 1'b0;
      end
      tick();
      c++;
    end
    check("done_seen", done8, 1);
    check("latency", c, lat_exp);
    check("quotient8", q8, eq);
    check("remainder8", r8, er);
    check("dbz8", dbz8, ez);
    tick();
    check("done_one_cycle", done8, 0);
    check("busy_back_idle", busy8, 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int c;
    logic [3:0] eq, er;
    eq = (b == 0) ? 4'hF : a / b;
    er = (b == 0) ? a : a % b;
    start4 = 1'b1; dd4 = a; dv4 = b;
    tick();
    start4 = 1'b0;
    c = 0;
    while (!done4 && c < 20) begin
      tick();
      c++;
    end
    check("done4_seen", done4, 1);
    check("quotient4", q4, eq);
    check("remainder4", r4, er);
    if (b != 0) begin
      check("identity4", q4 * b + r4, a);
      check("rem_lt_div4", r4 < b, 1);
    end
    tick();
  endtask

  initial begin
    int k_first;
    int dones;
    int perm[256];
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    start8 = 1'b0; dd8 = '0; dv8 = '0;
    start4 = 1'b0; dd4 = '0; dv4 = '0;
    tick();
    tick();
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_q", q8, 0);
    check("rst_r", r8, 0);
    check("rst_dbz", dbz8, 0);
    check("rst_busy4", busy4, 0);
    rst_n = 1'b1;
    tick();

    // 100 / 7, then results held while idle
    op8(8'd100, 8'd7, 1'b0, 0);
    repeat (3) tick();
    check("held_q", q8, 14);
    check("held_r", r8, 2);

    // back-to-back with start held high
    op8(8'd255, 8'd1, 1'b1, 0);
    k_first = k_prev;
    op8(8'd5, 8'd9, 1'b1, 0);
    check("restart_spacing", k_prev - k_first, 10);
    start8 = 1'b0;
    tick();

    // zero divisor
    op8(8'd200, 8'd0, 1'b0, 0);
    tick();

    // stray start during RUN is ignored
    op8(8'd77, 8'd6, 1'b0, 3);
    dones = 0;
    repeat (12) begin
      tick();
      if (done8) dones++;
    end
    check("no_extra_done", dones, 0);

    // reset aborts mid-run
    op8(8'd100, 8'd7, 1'b0, 0);
    start8 = 1'b1; dd8 = 8'd200; dv8 = 8'd3;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_q", q8, 0);
    check("abort_r", r8, 0);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      tick();
      if (done8) dones++;
    end
    check("abort_no_done", dones, 0);
    op8(8'd200, 8'd3, 1'b0, 0);

    // randomized N=8 operations
    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      op8(a, b, 1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    // N=4: every operand pair, visited in shuffled order
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = 8'(perm[i]);
      op4(p[7:4], p[3:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
